// File: rtl/generador_secuencia.sv
// generador_secuencia: MSB-first serial transmitter driving the single-wire dato line.
// Define GENERADOR_PARIDAD_EN to append an even-parity bit after the data bits.
module generador_secuencia #(
    parameter int ANCHO      = 16,
    parameter int CICLOS_BIT = 2,
    localparam int LW        = $clog2(ANCHO)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iniciar,
    input  logic [ANCHO-1:0] palabra,
    input  logic [LW-1:0]    longitud,
    input  logic             cancelar,
    output logic             listo,
    output logic             ocupado,
    output logic             dato,
    output logic             fin
);
    localparam int CW = (CICLOS_BIT > 1) ? $clog2(CICLOS_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CICLOS_BIT - 1);
    localparam logic [LW-1:0] IDX_MAX = LW'(ANCHO - 1);
`ifdef GENERADOR_PARIDAD_EN
    typedef enum logic [1:0] {REPOSO, TRANSMITE, PARIDAD} estado_t;
`else
    typedef enum logic [0:0] {REPOSO, TRANSMITE} estado_t;
`endif
    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] palabra_q, palabra_d;
    logic [LW-1:0]    idx_q, idx_d, idx_ini;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dato_q, dato_d;
    logic             fin_bit;
`ifdef GENERADOR_PARIDAD_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        idx_ini   = (longitud == '0) ? IDX_MAX : longitud - 1'b1;
        fin_bit   = (cnt_q == CNT_MAX);
        estado_d  = estado_q;
        palabra_d = palabra_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        dato_d    = dato_q;
`ifdef GENERADOR_PARIDAD_EN
        par_d     = par_q;
`endif
        case (estado_q)
            REPOSO: begin
                // cancelar takes priority over a simultaneous request
                if (iniciar && !cancelar) begin
                    estado_d  = TRANSMITE;
                    palabra_d = palabra;
                    idx_d     = idx_ini;
                    cnt_d     = '0;
                    dato_d    = palabra[idx_ini];
`ifdef GENERADOR_PARIDAD_EN
                    par_d     = palabra[idx_ini];
`endif
                end
            end
            TRANSMITE: begin
                if (cancelar) begin
                    estado_d = REPOSO;
                    dato_d   = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = fin_bit ? '0 : cnt_q + 1'b1;
                    if (fin_bit && idx_q == '0) begin
`ifdef GENERADOR_PARIDAD_EN
                        estado_d = PARIDAD;
                        dato_d   = par_q;
`else
                        estado_d = REPOSO;
                        dato_d   = 1'b0;
`endif
                    end else if (fin_bit) begin
                        idx_d  = idx_q - 1'b1;
                        dato_d = palabra_q[idx_q - 1'b1];
`ifdef GENERADOR_PARIDAD_EN
                        par_d  = par_q ^ palabra_q[idx_q - 1'b1];
`endif
                    end
                end
            end
`ifdef GENERADOR_PARIDAD_EN
            PARIDAD: begin
                if (cancelar || fin_bit) begin
                    estado_d = REPOSO;
                    dato_d   = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q  <= REPOSO;
            palabra_q <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            dato_q    <= 1'b0;
`ifdef GENERADOR_PARIDAD_EN
            par_q     <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            palabra_q <= palabra_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            dato_q    <= dato_d;
`ifdef GENERADOR_PARIDAD_EN
            par_q     <= par_d;
`endif
        end
    end

    assign listo   = (estado_q == REPOSO);
    assign ocupado = ~listo;
    assign dato    = dato_q;
`ifdef GENERADOR_PARIDAD_EN
    assign fin     = (estado_q == PARIDAD) && fin_bit && !cancelar;
`else
    assign fin     = (estado_q == TRANSMITE) && fin_bit && (idx_q == '0) && !cancelar;
`endif
endmodule
